// File: rtl/vm_pkg.sv
// vm_pkg: shared state encoding and credit width sizing for the vending credit FSM
package vm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    // Largest credit is PRICE-1 plus both coins at once; return bits needed to hold it.
    function automatic int credit_width(input int price, input int lo, input int hi);
        return $clog2(price + lo + hi);
    endfunction

endpackage

// File: rtl/vm_idle_timer.sv
// vm_idle_timer: counts idle cycles and flags expiry at TIMEOUT_CYC-1 (used with VM_TIMEOUT_EN)
module vm_idle_timer #(
    parameter int TIMEOUT_CYC = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] count;

    assign expire = (count == CW'(TIMEOUT_CYC - 1));

    // Count up while not cleared, holding at the expiry value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (!expire)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/vending_credit_fsm.sv
// vending_credit_fsm: two-coin credit accumulator with dispense, change handshake and cancel refund.
// Optional idle auto-refund when VM_TIMEOUT_EN is defined.
module vending_credit_fsm
    import vm_pkg::*;
#(
    parameter int COIN_LO_VAL = 5,
    parameter int COIN_HI_VAL = 10,
    parameter int PRICE       = 15,
    parameter int CREDIT_W    = 5,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_lo,
    input  logic                coin_hi,
    input  logic                cancel,
    input  logic                change_ack,
    output logic                dispense,
    output logic                change_vld,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic                busy
);

    if (PRICE <= 0) begin : g_bad_price
        $error("vending_credit_fsm: PRICE must be > 0");
    end
    if (CREDIT_W < credit_width(PRICE, COIN_LO_VAL, COIN_HI_VAL)) begin : g_bad_width
        $error("vending_credit_fsm: CREDIT_W too small for PRICE-1+COIN_LO_VAL+COIN_HI_VAL");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("vending_credit_fsm: TIMEOUT_CYC must be >= 2");
    end

    localparam logic [CREDIT_W-1:0] LO_C    = CREDIT_W'(COIN_LO_VAL);
    localparam logic [CREDIT_W-1:0] HI_C    = CREDIT_W'(COIN_HI_VAL);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n;
    logic [CREDIT_W-1:0] change, change_n;
    logic [CREDIT_W-1:0] coin_val, sum;
    logic                any_coin, timeout;

    assign any_coin = coin_lo | coin_hi;
    assign coin_val = (coin_lo ? LO_C : '0) + (coin_hi ? HI_C : '0);
    assign sum      = credit + coin_val;

`ifdef VM_TIMEOUT_EN
    vm_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state != COLLECT) | any_coin),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // State, credit and pending change registers; reset discards everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            change      <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            change      <= change_n;
            coin_reject <= busy & any_coin;
        end
    end

    // Next state: accumulate coins, dispense at PRICE, refund on cancel/timeout, hold change until ack.
    always_comb begin
        state_n  = state;
        credit_n = credit;
        change_n = change;
        case (state)
            IDLE, COLLECT: begin
                if (state == COLLECT && (cancel || timeout)) begin
                    state_n  = CHANGE;
                    change_n = sum;
                    credit_n = '0;
                end else if (sum >= PRICE_C) begin
                    state_n  = DISPENSE;
                    change_n = sum - PRICE_C;
                    credit_n = sum;
                end else if (sum != '0) begin
                    state_n  = COLLECT;
                    credit_n = sum;
                end
            end
            DISPENSE: begin
                state_n  = (change != '0) ? CHANGE : IDLE;
                credit_n = '0;
            end
            CHANGE: begin
                state_n  = change_ack ? IDLE : CHANGE;
                change_n = change_ack ? '0 : change;
            end
            default: begin
                state_n  = IDLE;
                credit_n = '0;
                change_n = '0;
            end
        endcase
    end

    assign dispense   = (state == DISPENSE);
    assign change_vld = (state == CHANGE);
    assign change_amt = change_vld ? change : '0;
    assign busy       = dispense | change_vld;

endmodule

// File: tb/tb_vending_credit_fsm.sv
// tb_vending_credit_fsm: directed bench with a per-cycle behavioural model (VM_TIMEOUT_EN adds the timeout test)
module tb_vending_credit_fsm;

    localparam int LO = 5, HI = 10, PR = 15, W = 5, TO = 8;

    logic         clk = 1'b0, reset = 1'b1;
    logic         coin_lo = 0, coin_hi = 0, cancel = 0, change_ack = 0;
    logic         dispense, change_vld, coin_reject, busy;
    logic [W-1:0] change_amt;

    int checks = 0, errors = 0;

    vending_credit_fsm #(
        .COIN_LO_VAL(LO), .COIN_HI_VAL(HI), .PRICE(PR), .CREDIT_W(W), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset), .coin_lo(coin_lo), .coin_hi(coin_hi), .cancel(cancel),
        .change_ack(change_ack), .dispense(dispense), .change_vld(change_vld),
        .change_amt(change_amt), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: credit accumulated, change owed, and whether a product/change is outstanding.
    int m_credit, m_change, m_idle;
    bit m_disp, m_vld, m_rej;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_credit = 0; m_change = 0; m_idle = 0;
            m_disp = 0; m_vld = 0; m_rej = 0;
        end else begin
            int  coins, s;
            bit  was_busy, collecting, to;
            coins      = (coin_lo ? LO : 0) + (coin_hi ? HI : 0);
            was_busy   = m_disp || m_vld;
            collecting = !was_busy && m_credit > 0;
`ifdef VM_TIMEOUT_EN
            to = collecting && m_idle == TO - 1;
`else
            to = 0;
`endif
            if (m_disp) begin
                m_disp = 0;
                m_vld  = m_change > 0;
            end else if (m_vld) begin
                if (change_ack) begin
                    m_vld = 0;
                    m_change = 0;
                end
            end else begin
                s = m_credit + coins;
                if (collecting && (cancel || to)) begin
                    m_change = s; m_credit = 0; m_vld = 1;
                end else if (s >= PR) begin
                    m_change = s - PR; m_credit = 0; m_disp = 1;
                end else
                    m_credit = s;
            end
            m_idle = (collecting && coins == 0 && !m_vld) ? m_idle + 1 : 0;
            m_rej  = was_busy && (coin_lo || coin_hi);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        check("dispense", dispense, m_disp);
        check("change_vld", change_vld, m_vld);
        check("busy", busy, m_disp || m_vld);
        check("coin_reject", coin_reject, m_rej);
        if (m_vld) check("change_amt", change_amt, m_change);
    end

    // One clock with the given inputs; returns shortly after the edge with outputs updated.
    task automatic step(input bit lo, input bit hi, input bit can, input bit ack);
        coin_lo = lo; coin_hi = hi; cancel = can; change_ack = ack;
        @(posedge clk);
        #2;
        coin_lo = 0; coin_hi = 0; cancel = 0; change_ack = 0;
    endtask

    initial begin
        @(posedge clk); #2;
        check("reset_vld", change_vld, 0);
        check("reset_disp", dispense, 0);
        reset = 0;
        // 1: lo, idle x2, hi -> exact price
        step(1, 0, 0, 0); check("t1_no_disp", dispense, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 1, 0, 0); check("t1_disp", dispense, 1); check("t1_busy", busy, 1);
        step(0, 0, 0, 0); check("t1_idle_busy", busy, 0); check("t1_no_change", change_vld, 0);
        // 2: hi, hi -> dispense, change 5 held until ack
        step(0, 1, 0, 0); step(0, 1, 0, 0); check("t2_disp", dispense, 1);
        step(0, 0, 0, 0); check("t2_vld", change_vld, 1); check("t2_amt", change_amt, 5);
        step(0, 0, 0, 0); step(0, 0, 0, 0); check("t2_amt_hold", change_amt, 5);
        step(0, 0, 0, 1); check("t2_ack_vld", change_vld, 0); check("t2_ack_busy", busy, 0);
        // 3: lo x3, then lo+hi together
        step(1, 0, 0, 0); step(1, 0, 0, 0); check("t3_two_lo", dispense, 0);
        step(1, 0, 0, 0); check("t3_three_lo", dispense, 1);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0); check("t3_both", dispense, 1);
        step(0, 0, 0, 0); check("t3_no_change", change_vld, 0);
        // 4: cancel refund, reject during CHANGE, cancel beating dispense
        step(1, 0, 0, 0); step(0, 0, 1, 0);
        check("t4_no_disp", dispense, 0); check("t4_vld", change_vld, 1); check("t4_amt", change_amt, 5);
        step(0, 1, 0, 0); check("t4_reject", coin_reject, 1); check("t4_amt_hold", change_amt, 5);
        step(0, 0, 0, 1); check("t4_reject_pulse", coin_reject, 0); check("t4_done", change_vld, 0);
        step(1, 0, 0, 0); step(0, 1, 1, 0);
        check("t4_cancel_wins", dispense, 0); check("t4_refund_all", change_amt, 15);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0); check("t4_cancel_idle", change_vld, 0);
        // 5: reset during change
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
        check("t5_pre_vld", change_vld, 1);
        #1 reset = 1;
        #1 check("t5_rst_vld", change_vld, 0); check("t5_rst_busy", busy, 0);
        @(posedge clk); #2 reset = 0;
        step(0, 1, 0, 0); check("t5_hi_only", dispense, 0);
        step(1, 0, 0, 0); check("t5_then_lo", dispense, 1);
        step(0, 0, 0, 0);
`ifdef VM_TIMEOUT_EN
        // 6: timeout refund 8 cycles after the coin
        step(1, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0);
        check("t6_before", change_vld, 0);
        step(0, 0, 0, 0); check("t6_vld", change_vld, 1); check("t6_amt", change_amt, 5);
        step(0, 0, 0, 1);
`endif
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
